rv_exec_unit: RTL and testbench
===============================

// Module: rv_exec_unit
// PURPOSE
// - RV32I single-cycle execute block for the rvsimple datapath.
// - Bundles the ALU, immediate generator, PC+4 adder, PC+immediate adder and JALR target formation.
// - Sits between the register file/operand muxes and the writeback/next-PC muxes.
// - Operand selection stays outside; this block computes all arithmetic results for one instruction.
// PARAMETERS
// - XLEN     32  data/address width; only 32 is supported.
// - REG_OUT  0   0: all outputs combinational. 1: all outputs registered, 1-cycle latency.
// PORTS
// - clock                  in   1   single clock, rising edge.
// - reset                  in   1   asynchronous, active-low; clears output registers (REG_OUT=1).
// - alu_function           in   5   ALU operation code (package rv_exec_pkg).
// - operand_a              in   32  ALU operand A (rs1 or PC, muxed upstream).
// - operand_b              in   32  ALU operand B (rs2 or immediate, muxed upstream).
// - inst                   in   32  current instruction word.
// - pc                     in   32  current program counter.
// - alu_result             out  32  ALU result.
// - alu_result_equal_zero  out  1   1 when alu_result == 0.
// - immediate              out  32  sign-extended immediate decoded from inst.
// - pc_plus_4              out  32  pc + 4.
// - pc_plus_immediate      out  32  pc + immediate (branch/JAL target).
// - jalr_target            out  32  {alu_result[31:1], 1'b0}.
// BEHAVIOUR
// - Single clock; reset asynchronous and active-low.
// - ALU: all arithmetic mod 2^32; shift amount = operand_b[4:0].
// - ADD 5'd1: a+b.
// - SUB 5'd2: a-b.
// - SLL 5'd3: a<<sh.
// - SRL 5'd4: logical a>>sh.
// - SRA 5'd5: arithmetic a>>>sh.
// - SEQ 5'd6: a==b.
// - SLT 5'd7: signed a<b.
// - SLTU 5'd8: unsigned a<b.
// - XOR 5'd9, OR 5'd10, AND 5'd11: bitwise.
// - COPY_B 5'd12: b.
// - Comparison ops (SEQ, SLT, SLTU) return 32'd1 or 32'd0.
// - Any other alu_function code gives result 0.
// - alu_result_equal_zero is derived from the final result, including for undefined codes (then 1).
// - Immediate select uses inst[6:0]:
//   - I-type for 0010011 (OP-IMM), 0000011 (LOAD), 1100111 (JALR).
//   - S-type for 0100011.
//   - B-type for 1100011; bit0 = 0.
//   - U-type for 0110111 and 0010111: {inst[31:12], 12'b0}.
//   - J-type for 1101111; bit0 = 0.
//   - All other opcodes: immediate = 0.
// - I, S, B and J immediates sign-extend from inst[31].
// - Adders wrap silently; no carry or overflow output. pc = 0xFFFFFFFC gives pc_plus_4 = 0.
// - REG_OUT=0:
//   - Pure combinational path; no state.
//   - clock and reset are unused but remain present.
// - REG_OUT=1:
//   - All six outputs are sampled on the rising clock edge; results appear one cycle after inputs.
//   - While reset=0, all outputs are 0 (alu_result_equal_zero = 0 as well), asserted asynchronously.
//   - Mid-operation reset clears outputs immediately; the first valid capture is the first edge after reset rises.
// STRUCTURE
// - Package rv_exec_pkg holds:
//   - ALU_* function codes.
//   - OPCODE_* localparams (LOAD, STORE, BRANCH, JALR, JAL, OP_IMM, LUI, AUIPC).
//   - XLEN default.
// - Sub-modules: rv_exec_alu (combinational ALU) and rv_exec_immgen (immediate decoder).
// - Both adders are inline expressions; the optional output register is a generate block in the top.
// TESTING
// - ADD a=7, b=5 -> result 12, equal_zero 0.
// - SUB a=b=5 -> result 0, equal_zero 1.
// - SRA a=0x80000000, b=4 -> 0xF8000000.
// - SRL with the same operands -> 0x08000000.
// - SLT a=0xFFFFFFFF, b=1 -> 1.
// - SLTU with the same operands -> 0.
// - Undefined code 5'd31 -> result 0, equal_zero 1.
// - inst 0xFFF00093 -> immediate 0xFFFFFFFF.
// - inst 0xFE000EE3 -> immediate 0xFFFFFFFC.
// - inst 0x12345037 -> immediate 0x12345000.
// - inst 0x00000000 -> immediate 0.
// - pc=0x00400000 with the B-type inst above:
//   - pc_plus_4 = 0x00400004.
//   - pc_plus_immediate = 0x003FFFFC.
// - ADD a=0x1001, b=0 -> jalr_target 0x1000.
// - REG_OUT=1:
//   - Outputs lag inputs by exactly one edge.
//   - Driving reset low between edges zeroes outputs at once.
//   - Outputs return to valid values at the first edge after reset goes high.

Source files
------------

// File: rtl/rv_exec_pkg.sv
// Shared constants for the RV32I execute block: ALU function codes,
// major opcodes used by the immediate decoder, and the datapath width.
package rv_exec_pkg;

   localparam int XLEN = 32;

   localparam logic [4:0] ALU_ADD    = 5'd1;
   localparam logic [4:0] ALU_SUB    = 5'd2;
   localparam logic [4:0] ALU_SLL    = 5'd3;
   localparam logic [4:0] ALU_SRL    = 5'd4;
   localparam logic [4:0] ALU_SRA    = 5'd5;
   localparam logic [4:0] ALU_SEQ    = 5'd6;
   localparam logic [4:0] ALU_SLT    = 5'd7;
   localparam logic [4:0] ALU_SLTU   = 5'd8;
   localparam logic [4:0] ALU_XOR    = 5'd9;
   localparam logic [4:0] ALU_OR     = 5'd10;
   localparam logic [4:0] ALU_AND    = 5'd11;
   localparam logic [4:0] ALU_COPY_B = 5'd12;

   localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
   localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
   localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
   localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
   localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
   localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
   localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

   typedef enum logic [2:0] {
      IMM_NONE,
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J
   } imm_fmt_t;

   // Map a major opcode to its immediate encoding; unknown opcodes yield no immediate.
   function automatic imm_fmt_t imm_format(input logic [6:0] opcode);
      imm_fmt_t fmt;
      case (opcode)
         OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: fmt = IMM_I;
         OPCODE_STORE:                            fmt = IMM_S;
         OPCODE_BRANCH:                           fmt = IMM_B;
         OPCODE_LUI, OPCODE_AUIPC:                fmt = IMM_U;
         OPCODE_JAL:                              fmt = IMM_J;
         default:                                 fmt = IMM_NONE;
      endcase
      return fmt;
   endfunction

endpackage

// File: rtl/rv_exec_if.sv
// Operand/result bundle between the operand muxes, the execute block and
// the writeback/next-PC muxes.
interface rv_exec_if;
   import rv_exec_pkg::*;

   logic [4:0]      alu_function;
   logic [XLEN-1:0] operand_a;
   logic [XLEN-1:0] operand_b;
   logic [XLEN-1:0] inst;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] alu_result;
   logic            alu_result_equal_zero;
   logic [XLEN-1:0] immediate;
   logic [XLEN-1:0] pc_plus_4;
   logic [XLEN-1:0] pc_plus_immediate;
   logic [XLEN-1:0] jalr_target;

   modport master (
      output alu_function, operand_a, operand_b, inst, pc,
      input  alu_result, alu_result_equal_zero, immediate,
             pc_plus_4, pc_plus_immediate, jalr_target
   );

   modport slave (
      input  alu_function, operand_a, operand_b, inst, pc,
      output alu_result, alu_result_equal_zero, immediate,
             pc_plus_4, pc_plus_immediate, jalr_target
   );

endinterface

// File: rtl/rv_exec_alu.sv
// Combinational RV32I ALU. Undefined function codes produce zero so the
// zero flag downstream reads as set for them.
module rv_exec_alu
   import rv_exec_pkg::*;
(
   input  logic [4:0]      alu_function,
   input  logic [XLEN-1:0] operand_a,
   input  logic [XLEN-1:0] operand_b,
   output logic [XLEN-1:0] result
);

   logic [4:0] shamt;

   assign shamt = operand_b[4:0];

   // Select one operation result per function code.
   always_comb begin
      result = '0;
      case (alu_function)
         ALU_ADD:    result = operand_a + operand_b;
         ALU_SUB:    result = operand_a - operand_b;
         ALU_SLL:    result = operand_a << shamt;
         ALU_SRL:    result = operand_a >> shamt;
         ALU_SRA:    result = XLEN'($signed(operand_a) >>> shamt);
         ALU_SEQ:    result = {{(XLEN-1){1'b0}}, operand_a == operand_b};
         ALU_SLT:    result = {{(XLEN-1){1'b0}}, $signed(operand_a) < $signed(operand_b)};
         ALU_SLTU:   result = {{(XLEN-1){1'b0}}, operand_a < operand_b};
         ALU_XOR:    result = operand_a ^ operand_b;
         ALU_OR:     result = operand_a | operand_b;
         ALU_AND:    result = operand_a & operand_b;
         ALU_COPY_B: result = operand_b;
         default:    result = '0;
      endcase
   end

endmodule

// File: rtl/rv_exec_immgen.sv
// Immediate decoder: picks the encoding from the major opcode and
// reassembles the sign-extended immediate.
module rv_exec_immgen
   import rv_exec_pkg::*;
(
   input  logic [XLEN-1:0] inst,
   output logic [XLEN-1:0] immediate
);

   imm_fmt_t fmt;

   assign fmt = imm_format(inst[6:0]);

   // Reassemble the immediate bit fields for the decoded format.
   always_comb begin
      immediate = '0;
      case (fmt)
         IMM_I:   immediate = {{20{inst[31]}}, inst[31:20]};
         IMM_S:   immediate = {{20{inst[31]}}, inst[31:25], inst[11:7]};
         IMM_B:   immediate = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                               inst[11:8], 1'b0};
         IMM_U:   immediate = {inst[31:12], 12'b0};
         IMM_J:   immediate = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                               inst[30:21], 1'b0};
         default: immediate = '0;
      endcase
   end

endmodule

// File: rtl/rv_exec_unit.sv
// RV32I execute block: ALU, immediate decode, PC+4, PC+immediate and JALR
// target. REG_OUT selects a purely combinational path or a one-cycle
// output register cleared by the asynchronous active-low reset.
module rv_exec_unit
   import rv_exec_pkg::*;
#(
   parameter int XLEN    = rv_exec_pkg::XLEN,
   parameter bit REG_OUT = 1'b0
) (
   input  logic        clock,
   input  logic        reset,
   rv_exec_if.slave    bus
);

   logic [XLEN-1:0] alu_result;
   logic            alu_zero;
   logic [XLEN-1:0] immediate;
   logic [XLEN-1:0] pc_plus_4;
   logic [XLEN-1:0] pc_plus_immediate;
   logic [XLEN-1:0] jalr_target;

   rv_exec_alu u_alu (
      .alu_function (bus.alu_function),
      .operand_a    (bus.operand_a),
      .operand_b    (bus.operand_b),
      .result       (alu_result)
   );

   rv_exec_immgen u_immgen (
      .inst      (bus.inst),
      .immediate (immediate)
   );

   // Adders wrap modulo 2^XLEN; no carry is exported.
   assign alu_zero          = (alu_result == '0);
   assign pc_plus_4         = bus.pc + XLEN'(4);
   assign pc_plus_immediate = bus.pc + immediate;
   assign jalr_target       = {alu_result[XLEN-1:1], 1'b0};

   if (REG_OUT) begin : g_reg
      logic [XLEN-1:0] alu_result_q;
      logic            alu_zero_q;
      logic [XLEN-1:0] immediate_q;
      logic [XLEN-1:0] pc_plus_4_q;
      logic [XLEN-1:0] pc_plus_immediate_q;
      logic [XLEN-1:0] jalr_target_q;

      // Capture every result each edge; reset forces all outputs, including the zero flag, low.
      always_ff @(posedge clock or negedge reset) begin
         if (!reset) begin
            alu_result_q        <= '0;
            alu_zero_q          <= 1'b0;
            immediate_q         <= '0;
            pc_plus_4_q         <= '0;
            pc_plus_immediate_q <= '0;
            jalr_target_q       <= '0;
         end else begin
            alu_result_q        <= alu_result;
            alu_zero_q          <= alu_zero;
            immediate_q         <= immediate;
            pc_plus_4_q         <= pc_plus_4;
            pc_plus_immediate_q <= pc_plus_immediate;
            jalr_target_q       <= jalr_target;
         end
      end

      assign bus.alu_result            = alu_result_q;
      assign bus.alu_result_equal_zero = alu_zero_q;
      assign bus.immediate             = immediate_q;
      assign bus.pc_plus_4             = pc_plus_4_q;
      assign bus.pc_plus_immediate     = pc_plus_immediate_q;
      assign bus.jalr_target           = jalr_target_q;
   end else begin : g_comb
      // clock and reset stay on the port list but carry no function here.
      logic unused_clk_rst;
      assign unused_clk_rst = clock ^ reset;

      assign bus.alu_result            = alu_result;
      assign bus.alu_result_equal_zero = alu_zero;
      assign bus.immediate             = immediate;
      assign bus.pc_plus_4             = pc_plus_4;
      assign bus.pc_plus_immediate     = pc_plus_immediate;
      assign bus.jalr_target           = jalr_target;
   end

endmodule

// File: tb/tb_rv_exec_unit.sv
// Bench for rv_exec_unit: one combinational and one registered instance
// driven with the same directed vectors; expectations queued at issue and
// compared by a negedge monitor.
module tb_rv_exec_unit;
   import rv_exec_pkg::*;

   typedef struct {
      logic [4:0]  fn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] inst;
      logic [31:0] pc;
      logic [31:0] res;
      logic        z;
      logic [31:0] imm;
      logic [31:0] p4;
      logic [31:0] pimm;
      logic [31:0] jalr;
   } vec_t;

   typedef struct {
      int          idx;
      int          cyc;
      logic [31:0] res;
      logic        z;
      logic [31:0] imm;
      logic [31:0] p4;
      logic [31:0] pimm;
      logic [31:0] jalr;
   } exp_t;

   logic clock = 1'b0;
   logic reset = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   vec_t vecs[$];
   exp_t q_c[$];
   exp_t q_r[$];
   exp_t e_c;
   exp_t e_r;

   rv_exec_if bus_c ();
   rv_exec_if bus_r ();

   rv_exec_unit #(.XLEN(32), .REG_OUT(1'b0)) u_comb (
      .clock (clock),
      .reset (reset),
      .bus   (bus_c)
   );

   rv_exec_unit #(.XLEN(32), .REG_OUT(1'b1)) u_reg (
      .clock (clock),
      .reset (reset),
      .bus   (bus_r)
   );

   always #5 clock = ~clock;

   always @(posedge clock) cyc <= cyc + 1;

   task automatic check32(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual %h required %h", name, act, req);
      end
   endtask

   task automatic check_out(input string who, input exp_t e,
                            input logic [31:0] res, input logic z,
                            input logic [31:0] imm, input logic [31:0] p4,
                            input logic [31:0] pimm, input logic [31:0] jalr);
      string t;
      t = $sformatf("%s_v%0d", who, e.idx);
      check32({t, "_result"}, res, e.res);
      check32({t, "_zero"}, {31'b0, z}, {31'b0, e.z});
      check32({t, "_imm"}, imm, e.imm);
      check32({t, "_pc4"}, p4, e.p4);
      check32({t, "_pcimm"}, pimm, e.pimm);
      check32({t, "_jalr"}, jalr, e.jalr);
   endtask

   task automatic add_vec(input logic [4:0] fn, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] inst, input logic [31:0] pc,
                          input logic [31:0] res, input logic z, input logic [31:0] imm,
                          input logic [31:0] p4, input logic [31:0] pimm,
                          input logic [31:0] jalr);
      vec_t v;
      v.fn = fn; v.a = a; v.b = b; v.inst = inst; v.pc = pc;
      v.res = res; v.z = z; v.imm = imm; v.p4 = p4; v.pimm = pimm; v.jalr = jalr;
      vecs.push_back(v);
   endtask

   task automatic apply(input vec_t v);
      bus_c.alu_function = v.fn; bus_r.alu_function = v.fn;
      bus_c.operand_a    = v.a;  bus_r.operand_a    = v.a;
      bus_c.operand_b    = v.b;  bus_r.operand_b    = v.b;
      bus_c.inst         = v.inst; bus_r.inst       = v.inst;
      bus_c.pc           = v.pc; bus_r.pc           = v.pc;
   endtask

   function automatic exp_t make_exp(input int idx, input vec_t v, input int c);
      exp_t e;
      e.idx = idx; e.cyc = c;
      e.res = v.res; e.z = v.z; e.imm = v.imm; e.p4 = v.p4; e.pimm = v.pimm; e.jalr = v.jalr;
      return e;
   endfunction

   // Monitor: combinational outputs settle within the issue cycle; registered
   // outputs are due once the edge after issue has passed.
   always @(negedge clock) begin
      if (q_c.size() > 0) begin
         e_c = q_c.pop_front();
         check_out("comb", e_c, bus_c.alu_result, bus_c.alu_result_equal_zero,
                   bus_c.immediate, bus_c.pc_plus_4, bus_c.pc_plus_immediate,
                   bus_c.jalr_target);
      end
      if (q_r.size() > 0 && cyc > q_r[0].cyc) begin
         e_r = q_r.pop_front();
         check_out("reg", e_r, bus_r.alu_result, bus_r.alu_result_equal_zero,
                   bus_r.immediate, bus_r.pc_plus_4, bus_r.pc_plus_immediate,
                   bus_r.jalr_target);
      end
   end

   task automatic check_reg_zero(input string tag);
      check32({tag, "_result"}, bus_r.alu_result, 32'h0);
      check32({tag, "_zero"}, {31'b0, bus_r.alu_result_equal_zero}, 32'h0);
      check32({tag, "_imm"}, bus_r.immediate, 32'h0);
      check32({tag, "_pc4"}, bus_r.pc_plus_4, 32'h0);
      check32({tag, "_pcimm"}, bus_r.pc_plus_immediate, 32'h0);
      check32({tag, "_jalr"}, bus_r.jalr_target, 32'h0);
   endtask

   initial begin
      //       fn          a             b             inst          pc            result        z     imm           pc+4          pc+imm        jalr
      add_vec(ALU_ADD,    32'd7,        32'd5,        32'h00000000, 32'h00000000, 32'd12,       1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'd12);
      add_vec(ALU_SUB,    32'd5,        32'd5,        32'hFFF00093, 32'h00000100, 32'd0,        1'b1, 32'hFFFFFFFF, 32'h00000104, 32'h000000FF, 32'd0);
      add_vec(ALU_SRA,    32'h80000000, 32'd4,        32'hFE000EE3, 32'h00400000, 32'hF8000000, 1'b0, 32'hFFFFFFFC, 32'h00400004, 32'h003FFFFC, 32'hF8000000);
      add_vec(ALU_SRL,    32'h80000000, 32'd4,        32'h12345037, 32'h00001000, 32'h08000000, 1'b0, 32'h12345000, 32'h00001004, 32'h12346000, 32'h08000000);
      add_vec(ALU_SLT,    32'hFFFFFFFF, 32'd1,        32'h00000000, 32'hFFFFFFFC, 32'd1,        1'b0, 32'h00000000, 32'h00000000, 32'hFFFFFFFC, 32'd0);
      add_vec(ALU_SLTU,   32'hFFFFFFFF, 32'd1,        32'h0080006F, 32'h00000200, 32'd0,        1'b1, 32'h00000008, 32'h00000204, 32'h00000208, 32'd0);
      add_vec(5'd31,      32'h00001234, 32'h00005678, 32'h00000000, 32'h00000000, 32'd0,        1'b1, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(ALU_ADD,    32'h00001001, 32'd0,        32'hFFF00067, 32'h00000010, 32'h00001001, 1'b0, 32'hFFFFFFFF, 32'h00000014, 32'h0000000F, 32'h00001000);
      add_vec(ALU_SLL,    32'd1,        32'h00000023, 32'h00812423, 32'h00000020, 32'd8,        1'b0, 32'h00000008, 32'h00000024, 32'h00000028, 32'd8);
      add_vec(ALU_SEQ,    32'hDEADBEEF, 32'hDEADBEEF, 32'hFFFFF017, 32'h00003000, 32'd1,        1'b0, 32'hFFFFF000, 32'h00003004, 32'h00002000, 32'd0);
      add_vec(ALU_XOR,    32'hF0F0F0F0, 32'hFF00FF00, 32'h00000033, 32'h00000000, 32'h0FF00FF0, 1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'h0FF00FF0);
      add_vec(ALU_OR,     32'hF0F0F0F0, 32'hFF00FF00, 32'h00000033, 32'h00000000, 32'hFFF0FFF0, 1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'hFFF0FFF0);
      add_vec(ALU_AND,    32'hF0F0F0F0, 32'hFF00FF00, 32'h00000033, 32'h00000000, 32'hF000F000, 1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'hF000F000);
      add_vec(ALU_COPY_B, 32'h00000000, 32'h80000001, 32'h7FF02083, 32'h00000000, 32'h80000001, 1'b0, 32'h000007FF, 32'h00000004, 32'h000007FF, 32'h80000000);
      add_vec(ALU_SLT,    32'd1,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'd0,        1'b1, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(ALU_SLTU,   32'd1,        32'hFFFFFFFF, 32'h00000000, 32'h00000000, 32'd1,        1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(ALU_ADD,    32'hFFFFFFFF, 32'd1,        32'h00000000, 32'h00000000, 32'd0,        1'b1, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(ALU_SEQ,    32'd1,        32'd2,        32'h00000000, 32'h00000000, 32'd0,        1'b1, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(5'd0,       32'd5,        32'd5,        32'h00000000, 32'h00000000, 32'd0,        1'b1, 32'h00000000, 32'h00000004, 32'h00000000, 32'd0);
      add_vec(ALU_SRA,    32'h70000000, 32'hFFFFFFE4, 32'h00000000, 32'h00000000, 32'h07000000, 1'b0, 32'h00000000, 32'h00000004, 32'h00000000, 32'h07000000);

      // Reset asserted from time 0 with live inputs: registered outputs must stay zero.
      apply(vecs[0]);
      #12;
      check_reg_zero("rst_init");
      @(negedge clock);
      reset = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         @(posedge clock);
         #1;
         apply(vecs[i]);
         q_c.push_back(make_exp(i, vecs[i], cyc));
         q_r.push_back(make_exp(i, vecs[i], cyc));
      end
      repeat (2) @(posedge clock);
      #1;

      // Mid-operation reset between edges clears at once and holds across an edge.
      apply(vecs[2]);
      q_r.push_back(make_exp(2, vecs[2], cyc));
      #2;
      reset = 1'b0;
      q_r.delete();
      #1;
      check_reg_zero("rst_mid");
      @(posedge clock);
      #1;
      check_reg_zero("rst_hold");
      #2;
      reset = 1'b1;
      #1;
      check32("rst_release_result", bus_r.alu_result, 32'h0);
      q_r.push_back(make_exp(2, vecs[2], cyc));
      repeat (2) @(posedge clock);
      @(negedge clock);
      #1;
      check32("queue_drain_reg", q_r.size(), 32'd0);
      check32("queue_drain_comb", q_c.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL watchdog: actual timeout required completion");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog expired");
   end

endmodule
